// File: rtl/bpc_pkg.sv
// Shared types, context codes and helpers for the bit-plane coder.
package bpc_pkg;

    typedef enum logic [2:0] {
        SB_LL  = 3'd0, SB_HL1 = 3'd1, SB_HL2 = 3'd2, SB_LH1 = 3'd3,
        SB_LH2 = 3'd4, SB_HH1 = 3'd5, SB_HH2 = 3'd6, SB_RSV = 3'd7
    } subband_e;

    typedef enum logic [1:0] {
        ST_IDLE, ST_ZC_MR, ST_SIGN, ST_DONE
    } state_e;

    localparam logic [4:0] CX_ZC0 = 5'd0,  CX_ZC1 = 5'd1,  CX_ZC2 = 5'd2;
    localparam logic [4:0] CX_ZC3 = 5'd3,  CX_ZC4 = 5'd4,  CX_ZC5 = 5'd5;
    localparam logic [4:0] CX_ZC6 = 5'd6,  CX_ZC7 = 5'd7,  CX_ZC8 = 5'd8;
    localparam logic [4:0] CX_SC0 = 5'd9,  CX_SC1 = 5'd10, CX_SC2 = 5'd11;
    localparam logic [4:0] CX_SC3 = 5'd12, CX_SC4 = 5'd13;
    localparam logic [4:0] CX_MR_FIRST0 = 5'd14;
    localparam logic [4:0] CX_MR_FIRST1 = 5'd15;
    localparam logic [4:0] CX_MR_LATER  = 5'd16;

    localparam logic [3:0] TOP_PLANE = 4'd14;

    // A coefficient counts as significant at plane p once any bit above p is set.
    function automatic logic is_sig(input logic [14:0] mag, input logic [3:0] p);
        return (mag >> ({1'b0, p} + 5'd1)) != 15'd0;
    endfunction

endpackage

// File: rtl/bitplane_coder_if.sv
// Symbol port towards the MQ coder: registered CX/D/plane with valid/ready.
interface bitplane_coder_if;
    logic [4:0] cx;
    logic       d;
    logic [3:0] plane;
    logic       cx_valid;
    logic       cx_ready;

    modport master (output cx, d, plane, cx_valid, input cx_ready);
    modport slave  (input cx, d, plane, cx_valid, output cx_ready);
endinterface

// File: rtl/bpc_ctx_lut.sv
// Combinational context formation (ZC, MR, sign) for the window centre at plane p.
// BPC_SIGN_CTX_EN enables neighbour-dependent sign contexts; otherwise sign is always CX_SC0.
module bpc_ctx_lut
    import bpc_pkg::*;
(
    input  logic [15:0] coef [9],
    input  logic [2:0]  subband,
    input  logic [3:0]  p,
    output logic [4:0]  zc_cx,
    output logic [4:0]  mr_cx,
    output logic [4:0]  sc_cx,
    output logic        sc_xor
);

    logic [8:0] sig;
    logic [1:0] h, v;
    logic [2:0] dg, hv;
    logic       first_ref;

    function automatic logic [4:0] zc_std(input logic [1:0] hc, input logic [1:0] vc,
                                          input logic [2:0] dc);
        if (hc == 2'd2) return CX_ZC8;
        if (hc == 2'd1) begin
            if (vc != 2'd0) return CX_ZC7;
            if (dc != 3'd0) return CX_ZC6;
            return CX_ZC5;
        end
        if (vc == 2'd2) return CX_ZC4;
        if (vc == 2'd1) return CX_ZC3;
        if (dc >= 3'd2) return CX_ZC2;
        if (dc == 3'd1) return CX_ZC1;
        return CX_ZC0;
    endfunction

    function automatic logic [4:0] zc_hh(input logic [2:0] hvc, input logic [2:0] dc);
        if (dc >= 3'd3) return CX_ZC8;
        if (dc == 3'd2) return (hvc >= 3'd1) ? CX_ZC7 : CX_ZC6;
        if (dc == 3'd1) return (hvc >= 3'd2) ? CX_ZC5 : (hvc == 3'd1) ? CX_ZC4 : CX_ZC3;
        return (hvc >= 3'd2) ? CX_ZC2 : (hvc == 3'd1) ? CX_ZC1 : CX_ZC0;
    endfunction

    always_comb begin
        for (int i = 0; i < 9; i++) sig[i] = is_sig(coef[i][14:0], p);
        h  = {1'b0, sig[3]} + {1'b0, sig[5]};
        v  = {1'b0, sig[1]} + {1'b0, sig[7]};
        dg = {2'b0, sig[0]} + {2'b0, sig[2]} + {2'b0, sig[6]} + {2'b0, sig[8]};
        hv = {1'b0, h} + {1'b0, v};

        case (subband_e'(subband))
            SB_HL1, SB_HL2: zc_cx = zc_std(v, h, dg);
            SB_HH1, SB_HH2: zc_cx = zc_hh(hv, dg);
            default:        zc_cx = zc_std(h, v, dg);
        endcase

        first_ref = (coef[4][14:0] >> ({1'b0, p} + 5'd2)) == 15'd0;
        if (!first_ref)                      mr_cx = CX_MR_LATER;
        else if (hv == 3'd0 && dg == 3'd0)   mr_cx = CX_MR_FIRST0;
        else                                 mr_cx = CX_MR_FIRST1;
    end

`ifdef BPC_SIGN_CTX_EN
    logic signed [2:0] hs, vs;

    function automatic logic signed [2:0] contrib(input logic [15:0] c, input logic s);
        if (!s) return 3'sd0;
        return c[15] ? -3'sd1 : 3'sd1;
    endfunction

    // Only the sign of each sum matters, so the clamp to -1..1 is implicit.
    always_comb begin
        hs     = contrib(coef[3], sig[3]) + contrib(coef[5], sig[5]);
        vs     = contrib(coef[1], sig[1]) + contrib(coef[7], sig[7]);
        sc_cx  = CX_SC0;
        sc_xor = 1'b0;
        if (hs > 3'sd0) begin
            sc_cx = (vs > 3'sd0) ? CX_SC4 : (vs == 3'sd0) ? CX_SC3 : CX_SC2;
        end else if (hs < 3'sd0) begin
            sc_xor = 1'b1;
            sc_cx  = (vs > 3'sd0) ? CX_SC2 : (vs == 3'sd0) ? CX_SC3 : CX_SC4;
        end else begin
            sc_cx  = (vs == 3'sd0) ? CX_SC0 : CX_SC1;
            sc_xor = (vs < 3'sd0);
        end
    end
`else
    assign sc_cx  = CX_SC0;
    assign sc_xor = 1'b0;
`endif

endmodule

// File: rtl/bitplane_coder.sv
// Bit-plane coder for the centre of a 3x3 window: FSM, window registers and handshakes.
// Optional macro BPC_SIGN_CTX_EN selects neighbour-dependent sign contexts.
module bitplane_coder
    import bpc_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bitplane_input_valid,
    input  logic [2:0]               subband,
    input  logic [15:0]              bitplane_data0,
    input  logic [15:0]              bitplane_data1,
    input  logic [15:0]              bitplane_data2,
    input  logic [15:0]              bitplane_data3,
    input  logic [15:0]              bitplane_data4,
    input  logic [15:0]              bitplane_data5,
    input  logic [15:0]              bitplane_data6,
    input  logic [15:0]              bitplane_data7,
    input  logic [15:0]              bitplane_data8,
    output logic                     bitplane_code_ready,
    output logic                     window_done,
    bitplane_coder_if.master         sym
);

    state_e      state_q, state_d;
    logic [3:0]  p_q, p_d;
    logic [15:0] coef_q [9];
    logic [15:0] coef_d [9];
    logic [2:0]  sb_q, sb_d;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic [4:0]  cx_q, cx_d;
    logic        d_q, d_d;
    logic [3:0]  plane_q, plane_d;

    logic [4:0]  zc_cx, mr_cx, sc_cx;
    logic        sc_xor, xfer, sign_next;
    logic [14:0] cur_mag, nxt_mag;

    // Contexts are formed from the next-cycle window and plane so the symbol outputs can be registered.
    bpc_ctx_lut u_lut (
        .coef    (coef_d),
        .subband (sb_d),
        .p       (p_d),
        .zc_cx   (zc_cx),
        .mr_cx   (mr_cx),
        .sc_cx   (sc_cx),
        .sc_xor  (sc_xor)
    );

    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        coef_d    = coef_q;
        sb_d      = sb_q;
        xfer      = valid_q & sym.cx_ready;
        cur_mag   = coef_q[4][14:0];
        sign_next = !is_sig(cur_mag, p_q) && cur_mag[p_q];

        case (state_q)
            ST_IDLE: begin
                if (ready_q && bitplane_input_valid) begin
                    coef_d[0] = bitplane_data0;  coef_d[1] = bitplane_data1;
                    coef_d[2] = bitplane_data2;  coef_d[3] = bitplane_data3;
                    coef_d[4] = bitplane_data4;  coef_d[5] = bitplane_data5;
                    coef_d[6] = bitplane_data6;  coef_d[7] = bitplane_data7;
                    coef_d[8] = bitplane_data8;
                    sb_d      = subband;
                    p_d       = TOP_PLANE;
                    state_d   = ST_ZC_MR;
                end
            end
            ST_ZC_MR: begin
                if (xfer) begin
                    if (sign_next)       state_d = ST_SIGN;
                    else if (p_q == 4'd0) state_d = ST_DONE;
                    else                 p_d     = p_q - 4'd1;
                end
            end
            ST_SIGN: begin
                if (xfer) begin
                    if (p_q == 4'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        p_d     = p_q - 4'd1;
                        state_d = ST_ZC_MR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_ZC_MR) || (state_d == ST_SIGN);
        done_d  = (state_d == ST_DONE);
        nxt_mag = coef_d[4][14:0];
        cx_d    = CX_ZC0;
        d_d     = 1'b0;
        plane_d = 4'd0;
        if (state_d == ST_ZC_MR) begin
            cx_d    = is_sig(nxt_mag, p_d) ? mr_cx : zc_cx;
            d_d     = nxt_mag[p_d];
            plane_d = p_d;
        end else if (state_d == ST_SIGN) begin
            cx_d    = sc_cx;
            d_d     = coef_d[4][15] ^ sc_xor;
            plane_d = p_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            p_q     <= 4'd0;
            sb_q    <= 3'd0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            cx_q    <= 5'd0;
            d_q     <= 1'b0;
            plane_q <= 4'd0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            sb_q    <= sb_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            cx_q    <= cx_d;
            d_q     <= d_d;
            plane_q <= plane_d;
        end
    end

    // NOTE: window storage is pure datapath, always overwritten on capture before use, so it carries no reset.
    always_ff @(posedge clk) begin
        coef_q <= coef_d;
    end

    assign bitplane_code_ready = ready_q;
    assign window_done         = done_q;
    assign sym.cx              = cx_q;
    assign sym.d               = d_q;
    assign sym.plane           = plane_q;
    assign sym.cx_valid        = valid_q;

endmodule
